// File: rtl/lb_csr_regs.sv
// Local Bus CSR block: scratch, control, prescaled event counter, sticky status
// and a small loopback FIFO, answering reads one cycle after acceptance.
module lb_csr_regs #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int STRB_W     = DATA_W/8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wen,
   input  logic [STRB_W-1:0] wstrb,
   output logic              wready,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              ren,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              ctrl_en,
   output logic              irq
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [ADDR_W-1:0] A_SCR  = ADDR_W'('h000);
   localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'('h004);
   localparam logic [ADDR_W-1:0] A_CNT  = ADDR_W'('h008);
   localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'('h00C);
   localparam logic [ADDR_W-1:0] A_FIFO = ADDR_W'('h010);

   logic [DATA_W-1:0] scratch_q, scratch_d;
   logic              en_q, en_d, ie_q, ie_d;
   logic [7:0]        presc_q, presc_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [7:0]        pcnt_q, pcnt_d;
   logic              ovf_q, ovf_d, udf_q, udf_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]  fcnt_q, fcnt_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              irq_q, irq_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

   logic              any_strb, wr_scr, wr_ctrl, wr_stat, clr;
   logic              rd_acc, push_req, pop_req, push_ok, pop_ok;
   logic              fifo_empty, fifo_full;
   logic [DATA_W-1:0] stat_word, fifo_head, rd_mux;

   assign any_strb   = |wstrb;
   assign wr_scr     = wen && (waddr == A_SCR);
   assign wr_ctrl    = wen && (waddr == A_CTRL);
   assign wr_stat    = wen && (waddr == A_STAT) && wstrb[0];
   assign clr        = wr_ctrl && wstrb[0] && wdata[2];

   // The cycle right after a response pulse is the bridge still holding ren.
   assign rd_acc     = ren && !rvalid_q;
   assign push_req   = wen && (waddr == A_FIFO) && any_strb;
   assign pop_req    = rd_acc && (raddr == A_FIFO);

   assign fifo_empty = (fcnt_q == '0);
   assign fifo_full  = (fcnt_q == CNT_W'(FIFO_DEPTH));
   assign pop_ok     = pop_req && !fifo_empty;
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign push_ok    = push_req && (!fifo_full || pop_ok);
   assign fifo_head  = fifo_empty ? '0 : mem_q[rptr_q];

   always_comb begin
      stat_word              = '0;
      stat_word[0]           = fifo_empty;
      stat_word[1]           = fifo_full;
      stat_word[2]           = ovf_q;
      stat_word[3]           = udf_q;
      stat_word[8 +: CNT_W]  = fcnt_q;
   end

   always_comb begin
      rd_mux = '0;
      case (raddr)
         A_SCR:   rd_mux = scratch_q;
         A_CTRL:  rd_mux = {16'h0, presc_q, 6'h0, ie_q, en_q};
         A_CNT:   rd_mux = cnt_q;
         A_STAT:  rd_mux = stat_word;
         A_FIFO:  rd_mux = fifo_head;
         default: rd_mux = '0;
      endcase
   end

   always_comb begin
      scratch_d = scratch_q;
      en_d      = en_q;
      ie_d      = ie_q;
      presc_d   = presc_q;
      cnt_d     = cnt_q;
      pcnt_d    = pcnt_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      fcnt_d    = fcnt_q;
      rvalid_d  = rd_acc;
      rdata_d   = rd_acc ? rd_mux : rdata_q;

      for (int b = 0; b < STRB_W; b++) begin
         if (wr_scr && wstrb[b]) scratch_d[8*b +: 8] = wdata[8*b +: 8];
      end

      if (wr_ctrl && wstrb[0]) begin
         en_d = wdata[0];
         ie_d = wdata[1];
      end
      if (wr_ctrl && wstrb[1]) presc_d = wdata[15:8];

      // >= keeps the prescaler bounded if PRESC is lowered mid-count.
      if (clr) begin
         cnt_d  = '0;
         pcnt_d = '0;
      end else if (en_q) begin
         if (pcnt_q >= presc_q) begin
            pcnt_d = '0;
            cnt_d  = cnt_q + 32'd1;
         end else begin
            pcnt_d = pcnt_q + 8'd1;
         end
      end

      if (push_ok) wptr_d = wptr_q + PTR_W'(1);
      if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   fcnt_d = fcnt_q + CNT_W'(1);
         2'b01:   fcnt_d = fcnt_q - CNT_W'(1);
         default: fcnt_d = fcnt_q;
      endcase

      // Sticky flags: a new event outranks a same-cycle W1C.
      ovf_d = (push_req && fifo_full && !pop_ok) || (ovf_q && !(wr_stat && wdata[2]));
      udf_d = (pop_req && fifo_empty)            || (udf_q && !(wr_stat && wdata[3]));
      irq_d = ie_q && (ovf_q || udf_q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         scratch_q <= '0;
         en_q      <= 1'b0;
         ie_q      <= 1'b0;
         presc_q   <= '0;
         cnt_q     <= '0;
         pcnt_q    <= '0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         fcnt_q    <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         scratch_q <= scratch_d;
         en_q      <= en_d;
         ie_q      <= ie_d;
         presc_q   <= presc_d;
         cnt_q     <= cnt_d;
         pcnt_q    <= pcnt_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         fcnt_q    <= fcnt_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         irq_q     <= irq_d;
      end
   end

   // Storage needs no reset: the empty check masks stale entries.
   always_ff @(posedge clk) begin
      if (rst && push_ok) mem_q[wptr_q] <= wdata;
   end

   assign wready  = 1'b1;
   assign rdata   = rdata_q;
   assign rvalid  = rvalid_q;
   assign ctrl_en = en_q;
   assign irq     = irq_q;

endmodule

// File: tb/tb_lb_csr_regs.sv
// Directed bench for lb_csr_regs: register map, counter, FIFO and status paths.
module tb_lb_csr_regs;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] waddr, raddr;
   logic [31:0] wdata, rdata;
   logic        wen, ren, wready, rvalid, ctrl_en, irq;
   logic [3:0]  wstrb;
   logic [31:0] d;

   int checks   = 0;
   int failures = 0;

   localparam logic [11:0] A_SCR = 12'h000, A_CTRL = 12'h004, A_CNT = 12'h008;
   localparam logic [11:0] A_STAT = 12'h00C, A_FIFO = 12'h010;

   lb_csr_regs #(.ADDR_W(12), .DATA_W(32), .STRB_W(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .waddr(waddr), .wdata(wdata), .wen(wen),
      .wstrb(wstrb), .wready(wready), .raddr(raddr), .ren(ren),
      .rdata(rdata), .rvalid(rvalid), .ctrl_en(ctrl_en), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] dat, input logic [3:0] s);
      waddr = a; wdata = dat; wstrb = s; wen = 1'b1;
      @(posedge clk); #1;
      wen = 1'b0; wstrb = 4'h0;
   endtask

   // Returns a sentinel if rvalid did not pulse in the response cycle.
   task automatic rd(input logic [11:0] a, output logic [31:0] dat);
      raddr = a; ren = 1'b1;
      @(posedge clk); #1;
      ren = 1'b0;
      dat = (rvalid === 1'b1) ? rdata : 32'hBAD0_BAD0;
      @(posedge clk); #1;
   endtask

   task automatic rdchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
      logic [31:0] v;
      rd(a, v);
      chk(tag, v, exp);
   endtask

   task automatic wrrd(input logic [11:0] wa, input logic [31:0] wd, input logic [11:0] ra,
                       output logic [31:0] dat);
      waddr = wa; wdata = wd; wstrb = 4'hF; wen = 1'b1;
      raddr = ra; ren = 1'b1;
      @(posedge clk); #1;
      wen = 1'b0; wstrb = 4'h0; ren = 1'b0;
      dat = (rvalid === 1'b1) ? rdata : 32'hBAD0_BAD0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b0; wen = 1'b0; ren = 1'b0; wstrb = 4'h0;
      waddr = '0; raddr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      chk("rst_ctrl_en", {31'h0, ctrl_en}, 32'h0);
      chk("rst_wready", {31'h0, wready}, 32'h1);
      rst = 1'b1;

      rdchk("rst_scratch", A_SCR, 32'h0);
      rdchk("rst_ctrl", A_CTRL, 32'h0);
      rdchk("rst_cnt", A_CNT, 32'h0);
      rdchk("rst_stat", A_STAT, 32'h1);
      rdchk("rst_fifo", A_FIFO, 32'h0);
      rdchk("unmapped", 12'h020, 32'h0);
      rdchk("stat_udf", A_STAT, 32'h9);
      wr(A_STAT, 32'h8, 4'h1);
      rdchk("stat_w1c", A_STAT, 32'h1);

      wr(A_SCR, 32'h1122_3344, 4'hF);
      wr(A_SCR, 32'hDEAD_BEEF, 4'b0101);
      rdchk("scr_strb", A_SCR, 32'h11AD_33EF);
      wr(A_SCR, 32'hFFFF_FFFF, 4'h0);
      rdchk("scr_nostrb", A_SCR, 32'h11AD_33EF);

      // PRESC=3: one count per four enabled cycles.
      wr(A_CTRL, 32'h0000_0301, 4'h3);
      chk("ctrl_en_on", {31'h0, ctrl_en}, 32'h1);
      repeat (40) @(posedge clk);
      #1;
      rdchk("cnt_40", A_CNT, 32'd10);
      wr(A_CTRL, 32'h0000_0305, 4'h3);
      rdchk("cnt_clr", A_CNT, 32'd0);
      repeat (8) @(posedge clk);
      #1;
      rdchk("cnt_after_clr", A_CNT, 32'd2);
      wr(A_CTRL, 32'h0000_0300, 4'h3);
      chk("ctrl_en_off", {31'h0, ctrl_en}, 32'h0);
      repeat (10) @(posedge clk);
      #1;
      rdchk("cnt_frozen", A_CNT, 32'd3);
      wr(A_CTRL, 32'h0000_0004, 4'h1);
      rdchk("ctrl_clr_rd0", A_CTRL, 32'h0000_0300);
      rdchk("cnt_clr_dis", A_CNT, 32'd0);

      for (int i = 1; i <= 5; i++) wr(A_FIFO, 32'(i), 4'hF);
      rdchk("stat_full_ovf", A_STAT, 32'h406);
      chk("irq_no_ie", {31'h0, irq}, 32'h0);
      wr(A_CTRL, 32'h0000_0002, 4'h1);
      @(posedge clk); #1;
      chk("irq_ie", {31'h0, irq}, 32'h1);
      wr(A_STAT, 32'h4, 4'h1);
      rdchk("stat_ovf_clr", A_STAT, 32'h402);
      chk("irq_cleared", {31'h0, irq}, 32'h0);

      wrrd(A_FIFO, 32'h6, A_FIFO, d);
      chk("full_pushpop_data", d, 32'h1);
      rdchk("full_pushpop_stat", A_STAT, 32'h402);

      raddr = A_FIFO; ren = 1'b1;
      @(posedge clk); #1;
      chk("hold_rvalid1", {31'h0, rvalid}, 32'h1);
      chk("hold_data", rdata, 32'h2);
      @(posedge clk); #1;
      chk("hold_rvalid2", {31'h0, rvalid}, 32'h0);
      ren = 1'b0;
      rdchk("hold_stat", A_STAT, 32'h300);

      rdchk("pop_3", A_FIFO, 32'h3);
      rdchk("pop_4", A_FIFO, 32'h4);
      rdchk("pop_6", A_FIFO, 32'h6);
      rdchk("pop_empty", A_FIFO, 32'h0);
      chk("irq_udf", {31'h0, irq}, 32'h1);
      rdchk("stat_udf2", A_STAT, 32'h9);
      wr(A_STAT, 32'hC, 4'h1);
      rdchk("stat_w1c_both", A_STAT, 32'h1);

      wrrd(A_FIFO, 32'h7, A_FIFO, d);
      chk("empty_pushpop_data", d, 32'h0);
      rdchk("empty_pushpop_stat", A_STAT, 32'h108);
      wr(A_STAT, 32'h8, 4'h1);
      rdchk("pop_7", A_FIFO, 32'h7);

      wr(A_FIFO, 32'hAA, 4'hF);
      wr(A_CTRL, 32'h1, 4'h1);
      raddr = A_FIFO; ren = 1'b1; rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_rvalid", {31'h0, rvalid}, 32'h0);
      chk("rst_mid_rdata", rdata, 32'h0);
      chk("rst_mid_ctrl_en", {31'h0, ctrl_en}, 32'h0);
      ren = 1'b0; rst = 1'b1;
      rdchk("rst_mid_stat", A_STAT, 32'h1);
      rdchk("rst_mid_scratch", A_SCR, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
